phase_accumulator_stage_multi: RTL and testbench



---
 rtl/synth_pkg.sv | 23 ++
 rtl/phase_slot_ram.sv | 40 ++++
 rtl/phase_accumulator_stage_multi.sv | 201 ++++++++++++++++++++
 tb/tb_phase_accumulator_stage_multi.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the operator synthesis pipeline stages: slot geometry,
// slot-id field extraction and the stage FSM state type.
package synth_pkg;

  localparam int unsigned NUM_VOICES_DEFAULT    = 32;
  localparam int unsigned NUM_OPERATORS_DEFAULT = 8;
  localparam int unsigned VO_W = $clog2(NUM_VOICES_DEFAULT * NUM_OPERATORS_DEFAULT);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Slot ids are laid out as {voice, operator}.
  function automatic int unsigned voice_id(input int unsigned vo, input int unsigned opBits);
    return vo >> opBits;
  endfunction

  function automatic int unsigned operator_id(input int unsigned vo, input int unsigned opBits);
    return vo & ((32'd1 << opBits) - 32'd1);
  endfunction

endpackage

// File: rtl/phase_slot_ram.sv
// Per-slot storage with one bit-masked write port and one registered read port.
// With BYPASS set, a read of the address being written returns the new word.
module phase_slot_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned WIDTH  = 25,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_WriteEnable,
  input  logic [ADDR_W-1:0] i_WriteAddr,
  input  logic [WIDTH-1:0]  i_WriteMask,
  input  logic [WIDTH-1:0]  i_WriteData,
  input  logic [ADDR_W-1:0] i_ReadAddr,
  output logic [WIDTH-1:0]  o_ReadData
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] merged;

  assign merged = (mem[i_WriteAddr] & ~i_WriteMask) | (i_WriteData & i_WriteMask);

  always_ff @(posedge i_Clock) begin
    if (i_WriteEnable) begin
      mem[i_WriteAddr] <= merged;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_ReadData <= '0;
    end else if (BYPASS && i_WriteEnable && (i_WriteAddr == i_ReadAddr)) begin
      o_ReadData <= merged;
    end else begin
      o_ReadData <= mem[i_ReadAddr];
    end
  end

endmodule

// File: rtl/phase_accumulator_stage_multi.sv
// Operator phase-accumulator stage: one wide fractional accumulator per voice-operator
// slot, advanced by a per-slot step each time the slot is presented; 2-cycle latency.
module phase_accumulator_stage_multi
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES    = NUM_VOICES_DEFAULT,
  parameter int unsigned NUM_OPERATORS = NUM_OPERATORS_DEFAULT,
  parameter int unsigned ACC_WIDTH     = 24,
  parameter int unsigned PHASE_WIDTH   = 16,
  localparam int unsigned SLOT_W = $clog2(NUM_VOICES * NUM_OPERATORS)
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_Valid,
  input  logic [SLOT_W-1:0]      i_VoiceOperator,
  output logic                   o_Ready,
  output logic                   o_Valid,
  output logic [SLOT_W-1:0]      o_VoiceOperator,
  output logic [PHASE_WIDTH-1:0] o_Phase,
  output logic                   o_NoteOn,
  output logic                   o_NoteTrigger,
  input  logic [1:0]             i_PhaseStepWriteEnable,
  input  logic                   i_NoteOnWriteEnable,
  input  logic                   i_KeySyncWriteEnable,
  input  logic [SLOT_W-1:0]      i_ConfigWriteAddr,
  input  logic [15:0]            i_ConfigWriteData
);

  localparam int unsigned NUM_SLOTS = NUM_VOICES * NUM_OPERATORS;
  localparam int unsigned OP_W      = $clog2(NUM_OPERATORS);
  localparam int unsigned VOICE_W   = $clog2(NUM_VOICES);
  localparam int unsigned NUM_WORDS = NUM_VOICES / 16;
  localparam int unsigned WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned HI_W      = ACC_WIDTH - 16;

  state_t              state;
  logic [SLOT_W-1:0]   clearCount;
  logic                running;

  // Clearing sweep after reset, then run forever.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state      <= CLEAR;
      clearCount <= '0;
      o_Ready    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clearCount <= clearCount + SLOT_W'(1);
          if (clearCount == SLOT_W'(NUM_SLOTS - 1)) begin
            state   <= RUN;
            o_Ready <= 1'b1;
          end
        end
        RUN:     o_Ready <= 1'b1;
        default: state   <= CLEAR;
      endcase
    end
  end

  assign running = (state == RUN);

  logic [NUM_VOICES-1:0] noteOn;
  logic [NUM_VOICES-1:0] keySync;
  logic [WORD_W-1:0]     cfgWord;

  assign cfgWord = WORD_W'(i_ConfigWriteAddr >> (OP_W + 4));

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      noteOn  <= '0;
      keySync <= '0;
    end else if (running) begin
      if (i_NoteOnWriteEnable)  noteOn[{cfgWord, 4'b0000} +: 16]  <= i_ConfigWriteData;
      if (i_KeySyncWriteEnable) keySync[{cfgWord, 4'b0000} +: 16] <= i_ConfigWriteData;
    end
  end

  // Clock 1: slot lookup.
  logic                 s1Valid;
  logic [SLOT_W-1:0]    s1Id;
  logic                 s1NoteOn;
  logic                 s1KeySync;
  logic [VOICE_W-1:0]   rdVoice;
  logic [ACC_WIDTH:0]   accRdData;
  logic [ACC_WIDTH-1:0] s1Step;

  assign rdVoice = VOICE_W'(voice_id(32'(i_VoiceOperator), OP_W));

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      s1Valid   <= 1'b0;
      s1Id      <= '0;
      s1NoteOn  <= 1'b0;
      s1KeySync <= 1'b0;
    end else begin
      s1Valid   <= i_Valid && running;
      s1Id      <= i_VoiceOperator;
      s1NoteOn  <= noteOn[rdVoice];
      s1KeySync <= keySync[rdVoice];
    end
  end

  // Clock 2: next accumulator value, written back and reported.
  logic                 trigger;
  logic [ACC_WIDTH-1:0] nextAcc;

  assign trigger = s1NoteOn && !accRdData[ACC_WIDTH];

  always_comb begin
    nextAcc = accRdData[ACC_WIDTH-1:0] + s1Step;
    if (s1KeySync && !s1NoteOn) begin
      nextAcc = '0;
    end else if (s1KeySync && trigger) begin
      nextAcc = s1Step;
    end
  end

  logic                 accWrEn;
  logic [SLOT_W-1:0]    accWrAddr;
  logic [ACC_WIDTH:0]   accWrData;

  assign accWrEn   = !running || s1Valid;
  assign accWrAddr = running ? s1Id : clearCount;
  assign accWrData = running ? {s1NoteOn, nextAcc} : '0;

  phase_slot_ram #(
    .DEPTH (NUM_SLOTS),
    .WIDTH (ACC_WIDTH + 1),
    .BYPASS(1'b1)
  ) accRam (
    .i_Clock      (i_Clock),
    .i_Reset_n    (i_Reset_n),
    .i_WriteEnable(accWrEn),
    .i_WriteAddr  (accWrAddr),
    .i_WriteMask  ({(ACC_WIDTH + 1){1'b1}}),
    .i_WriteData  (accWrData),
    .i_ReadAddr   (i_VoiceOperator),
    .o_ReadData   (accRdData)
  );

  logic                 stepWrEn;
  logic [SLOT_W-1:0]    stepWrAddr;
  logic [ACC_WIDTH-1:0] stepWrMask;
  logic [ACC_WIDTH-1:0] stepWrData;

  assign stepWrEn   = !running || (|i_PhaseStepWriteEnable);
  assign stepWrAddr = running ? i_ConfigWriteAddr : clearCount;

  // Step halves are written independently; the sweep zeroes the whole word.
  always_comb begin
    stepWrMask = '0;
    stepWrData = '0;
    if (!running) begin
      stepWrMask = '1;
    end else begin
      if (i_PhaseStepWriteEnable[0]) begin
        stepWrMask[15:0] = '1;
        stepWrData[15:0] = i_ConfigWriteData;
      end
      if (i_PhaseStepWriteEnable[1]) begin
        stepWrMask[ACC_WIDTH-1:16] = '1;
        stepWrData[ACC_WIDTH-1:16] = i_ConfigWriteData[HI_W-1:0];
      end
    end
  end

  phase_slot_ram #(
    .DEPTH (NUM_SLOTS),
    .WIDTH (ACC_WIDTH),
    .BYPASS(1'b0)
  ) stepRam (
    .i_Clock      (i_Clock),
    .i_Reset_n    (i_Reset_n),
    .i_WriteEnable(stepWrEn),
    .i_WriteAddr  (stepWrAddr),
    .i_WriteMask  (stepWrMask),
    .i_WriteData  (stepWrData),
    .i_ReadAddr   (i_VoiceOperator),
    .o_ReadData   (s1Step)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Valid         <= 1'b0;
      o_VoiceOperator <= '0;
      o_Phase         <= '0;
      o_NoteOn        <= 1'b0;
      o_NoteTrigger   <= 1'b0;
    end else begin
      o_Valid <= s1Valid;
      if (s1Valid) begin
        o_VoiceOperator <= s1Id;
        o_Phase         <= nextAcc[ACC_WIDTH-1 -: PHASE_WIDTH];
        o_NoteOn        <= s1NoteOn;
        o_NoteTrigger   <= trigger;
      end
    end
  end

endmodule

// File: tb/tb_phase_accumulator_stage_multi.sv
// Self-checking bench: directed scenarios plus a randomized stream against a
// per-slot sequential reference model of the phase accumulator stage.
module tb_phase_accumulator_stage_multi;

  localparam int unsigned NV = 32;
  localparam int unsigned NO = 8;
  localparam int unsigned NS = NV * NO;
  localparam int unsigned AW = 24;
  localparam int unsigned PW = 16;

  typedef struct packed {
    logic        v;
    logic [7:0]  id;
    logic [15:0] ph;
    logic        n;
    logic        t;
  } obs_t;

  logic        clk;
  logic        rstN;
  logic        iValid;
  logic [7:0]  iVo;
  logic        oReady;
  logic        oValid;
  logic [7:0]  oVo;
  logic [15:0] oPhase;
  logic        oNoteOn;
  logic        oTrig;
  logic [1:0]  stepWe;
  logic        noteWe;
  logic        keyWe;
  logic [7:0]  cfgAddr;
  logic [15:0] cfgData;

  int checks = 0;
  int errors = 0;

  int unsigned mAcc  [NS];
  int unsigned mStep [NS];
  bit          mLast [NS];
  bit          mNoteOn  [NV];
  bit          mKeySync [NV];
  obs_t        lastOut;

  phase_accumulator_stage_multi dut (
    .i_Clock               (clk),
    .i_Reset_n             (rstN),
    .i_Valid               (iValid),
    .i_VoiceOperator       (iVo),
    .o_Ready               (oReady),
    .o_Valid               (oValid),
    .o_VoiceOperator       (oVo),
    .o_Phase               (oPhase),
    .o_NoteOn              (oNoteOn),
    .o_NoteTrigger         (oTrig),
    .i_PhaseStepWriteEnable(stepWe),
    .i_NoteOnWriteEnable   (noteWe),
    .i_KeySyncWriteEnable  (keyWe),
    .i_ConfigWriteAddr     (cfgAddr),
    .i_ConfigWriteData     (cfgData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void resetModel();
    for (int i = 0; i < NS; i++) begin
      mAcc[i] = 0; mStep[i] = 0; mLast[i] = 1'b0;
    end
    for (int i = 0; i < NV; i++) begin
      mNoteOn[i] = 1'b0; mKeySync[i] = 1'b0;
    end
    lastOut = '0;
  endfunction

  // Reference: one slot sample in program order, returns what the stage must report.
  function automatic obs_t present(input int id);
    int          v;
    bit          trig;
    int unsigned nxt;
    obs_t        e;
    v    = id / NO;
    trig = mNoteOn[v] && !mLast[id];
    if (mKeySync[v] && !mNoteOn[v])  nxt = 0;
    else if (mKeySync[v] && trig)    nxt = mStep[id];
    else                             nxt = (mAcc[id] + mStep[id]) % (32'd1 << AW);
    mAcc[id]  = nxt;
    mLast[id] = mNoteOn[v];
    e = {1'b1, 8'(id), 16'(nxt >> (AW - PW)), mNoteOn[v], trig};
    lastOut = e;
    return e;
  endfunction

  function automatic void applyCfg(input logic [1:0] se, input logic ne, input logic ke,
                                   input int addr, input logic [15:0] d);
    int w;
    w = addr >> 7;
    if (se[0]) mStep[addr] = (mStep[addr] & 32'hFF0000) | 32'(d);
    if (se[1]) mStep[addr] = (mStep[addr] & 32'h00FFFF) | ((32'(d) & 32'hFF) << 16);
    for (int b = 0; b < 16; b++) begin
      if (ne) mNoteOn[w * 16 + b]  = d[b];
      if (ke) mKeySync[w * 16 + b] = d[b];
    end
  endfunction

  function automatic obs_t observe();
    return {oValid, oVo, oPhase, oNoteOn, oTrig};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] se, input logic ne, input logic ke,
                     input int addr, input logic [15:0] d);
    stepWe = se; noteWe = ne; keyWe = ke; cfgAddr = 8'(addr); cfgData = d;
    tick();
    applyCfg(se, ne, ke, addr, d);
    stepWe = 2'b00; noteWe = 1'b0; keyWe = 1'b0;
  endtask

  task automatic setStep(input int slot, input logic [23:0] val);
    cfg(2'b01, 1'b0, 1'b0, slot, val[15:0]);
    cfg(2'b10, 1'b0, 1'b0, slot, {8'h00, val[23:16]});
  endtask

  task automatic setVoiceBit(input bit isKey, input int voice, input bit val);
    logic [15:0] d;
    int w;
    w = voice / 16;
    for (int b = 0; b < 16; b++) d[b] = isKey ? mKeySync[w * 16 + b] : mNoteOn[w * 16 + b];
    d[voice % 16] = val;
    cfg(2'b00, !isKey, isKey, w << 7, d);
  endtask

  task automatic presentGap(input int id, output obs_t e);
    iValid = 1'b1; iVo = 8'(id);
    e = present(id);
    tick();
    iValid = 1'b0;
    tick();
  endtask

  task automatic waitReady(input string tag);
    int readyAt;
    bit seenValid;
    readyAt = 0; seenValid = 1'b0;
    for (int n = 1; n <= 400 && readyAt == 0; n++) begin
      iVo = 8'($urandom);
      tick();
      if (oValid) seenValid = 1'b1;
      if (oReady) readyAt = n;
    end
    iValid = 1'b0;
    checks++;
    if (readyAt != 256) begin
      errors++; $display("FAIL %s ready_cycle got %0d exp 256", tag, readyAt);
    end
    checks++;
    if (seenValid) begin
      errors++; $display("FAIL %s valid_before_ready got 1 exp 0", tag);
    end
    resetModel();
  endtask

  task automatic test_reset();
    iValid = 1'b1;
    rstN = 1'b0;
    tick(); tick();
    checks++;
    if (observe() !== '0 || oReady !== 1'b0) begin
      errors++; $display("FAIL reset_values got %h ready %b exp 0", observe(), oReady);
    end
    rstN = 1'b1;
    waitReady("reset");
  endtask

  task automatic test_allSlotsZero();
    obs_t prev, cur;
    prev = '0; cur = '0;
    for (int i = 0; i <= NS; i++) begin
      if (i < NS) begin iValid = 1'b1; iVo = 8'(i); cur = present(i); end
      else iValid = 1'b0;
      tick();
      if (i > 0) begin
        checks++;
        if (observe() !== prev || oPhase !== 16'h0000) begin
          errors++; $display("FAIL first_read slot %0d got %h exp %h", i - 1, observe(), prev);
        end
      end
      prev = cur;
    end
    tick();
  endtask

  task automatic test_keySync();
    obs_t e;
    setStep(5, 24'h000100);
    setVoiceBit(1'b1, 0, 1'b1);
    setVoiceBit(1'b0, 0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      presentGap(5, e);
      checks++;
      if (observe() !== e || oPhase !== 16'(k) || oTrig !== (k == 1) || oNoteOn !== 1'b1) begin
        errors++; $display("FAIL keysync k=%0d got %h exp %h", k, observe(), e);
      end
      tick(); tick();
    end
    setVoiceBit(1'b0, 0, 1'b0);
    presentGap(5, e);
    checks++;
    if (observe() !== e || oPhase !== 16'h0000 || oNoteOn !== 1'b0 || oValid !== 1'b1) begin
      errors++; $display("FAIL keysync_noteoff got %h exp %h", observe(), e);
    end
  endtask

  task automatic test_fractional();
    obs_t e;
    setStep(8'h21, 24'h000080);
    for (int k = 1; k <= 4; k++) begin
      presentGap(8'h21, e);
      checks++;
      if (observe() !== e || oPhase !== 16'(k / 2)) begin
        errors++; $display("FAIL fractional k=%0d got %h exp %h", k, observe(), e);
      end
    end
    setStep(8'h22, 24'hFFFF00);
    presentGap(8'h22, e);
    checks++;
    if (observe() !== e || oPhase !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_first got %h exp %h", observe(), e);
    end
    presentGap(8'h22, e);
    checks++;
    if (observe() !== e || oPhase !== 16'hFFFE) begin
      errors++; $display("FAIL wrap_second got %h exp %h", observe(), e);
    end
  endtask

  task automatic test_freeRun();
    obs_t e;
    setStep(8'h40, 24'h010000);
    for (int k = 1; k <= 5; k++) begin
      if (k == 4) setVoiceBit(1'b0, 8, 1'b1);
      presentGap(8'h40, e);
      checks++;
      if (observe() !== e || oPhase !== 16'(k * 256) || oNoteOn !== (k >= 4) || oTrig !== (k == 4)) begin
        errors++; $display("FAIL freerun k=%0d got %h exp %h", k, observe(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t prev, cur;
    prev = '0; cur = '0;
    setStep(8'h9A, 24'h000100);
    setVoiceBit(1'b1, 19, 1'b1);
    setVoiceBit(1'b0, 19, 1'b1);
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) begin iValid = 1'b1; iVo = 8'h9A; cur = present(8'h9A); end
      else iValid = 1'b0;
      tick();
      if (i > 0) begin
        checks++;
        if (observe() !== prev || oPhase !== 16'(i) || oTrig !== (i == 1) || oValid !== 1'b1) begin
          errors++; $display("FAIL back_to_back i=%0d got %h exp %h", i, observe(), prev);
        end
      end
      prev = cur;
    end
    tick();
  endtask

  task automatic test_random();
    obs_t prev, cur, obs;
    int   pool [8];
    int   id;
    logic [1:0] se;
    logic ne, ke;
    int   addr;
    logic [15:0] d;
    bit   bad;
    for (int i = 0; i < 8; i++) pool[i] = int'($urandom_range(0, NS - 1));
    pool[1] = pool[0] ^ 1;
    prev = '0; cur = '0;
    for (int i = 0; i <= 1500; i++) begin
      se = 2'b00; ne = 1'b0; ke = 1'b0; addr = 0; d = '0;
      if (i < 1500 && ($urandom % 4) == 0) begin
        se = 2'($urandom); ne = 1'($urandom); ke = 1'($urandom);
        addr = (($urandom % 2) == 0) ? pool[$urandom % 8] : int'($urandom_range(0, NS - 1));
        d = 16'($urandom);
      end
      stepWe = se; noteWe = ne; keyWe = ke; cfgAddr = 8'(addr); cfgData = d;
      if (i < 1500 && ($urandom % 4) != 0) begin
        id = pool[$urandom % 8];
        iValid = 1'b1; iVo = 8'(id);
        cur = present(id);
      end else begin
        iValid = 1'b0;
        cur = {1'b0, lastOut.id, lastOut.ph, 2'b00};
      end
      applyCfg(se, ne, ke, addr, d);
      tick();
      if (i > 0) begin
        obs = observe();
        bad = prev.v ? (obs !== prev)
                     : ({obs.v, obs.id, obs.ph} !== {prev.v, prev.id, prev.ph});
        checks++;
        if (bad) begin
          errors++; $display("FAIL random i=%0d got %h exp %h", i - 1, obs, prev);
        end
      end
      prev = cur;
    end
    stepWe = 2'b00; noteWe = 1'b0; keyWe = 1'b0; iValid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_midReset();
    obs_t e;
    iValid = 1'b1; iVo = 8'h05;
    tick(); tick(); tick();
    rstN = 1'b0;
    #2;
    checks++;
    if (observe() !== '0 || oReady !== 1'b0) begin
      errors++; $display("FAIL async_reset got %h ready %b exp 0", observe(), oReady);
    end
    tick();
    rstN = 1'b1;
    waitReady("midreset");
    setStep(5, 24'h000100);
    presentGap(5, e);
    checks++;
    if (observe() !== e || oPhase !== 16'h0001 || oNoteOn !== 1'b0) begin
      errors++; $display("FAIL restart_phase got %h exp %h", observe(), e);
    end
  endtask

  initial begin
    rstN = 1'b0; iValid = 1'b0; iVo = '0;
    stepWe = 2'b00; noteWe = 1'b0; keyWe = 1'b0; cfgAddr = '0; cfgData = '0;
    resetModel();
    test_reset();
    test_allSlotsZero();
    test_keySync();
    test_fractional();
    test_freeRun();
    test_back_to_back();
    test_random();
    test_midReset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
